dram_lsu_ctrl: RTL and testbench

Load/store access controller that sits directly upstream of the 32-bit byte-enabled single-port data RAM (14-bit word address, 1-cycle read latency, no output register). It accepts RISC-V load/store requests from the core's memory stage and checks address range, alignment and funct3. It translates byte addresses into RAM word address, byte enables and lane-replicated write data. It returns sign/zero-extended load data or a store acknowledge over a valid/ready response channel.

---
 rtl/dram_lsu_ctrl_if.sv | 33 +++
 rtl/dram_lsu_ctrl.sv | 138 +++++++++++++
 tb/tb_dram_lsu_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dram_lsu_ctrl_if.sv
// Signal bundle between the core memory stage, dram_lsu_ctrl and the data RAM.
// The slave modport is the controller's view; master is the core/RAM environment.
interface dram_lsu_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wr_data;
  logic                  mem_wr_en;
  logic [3:0]            mem_wr_byte_en;
  logic [31:0]           mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wr_data, mem_wr_en, mem_wr_byte_en
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wr_data, mem_wr_en, mem_wr_byte_en
  );
endinterface

// File: rtl/dram_lsu_ctrl.sv
// Load/store controller in front of a byte-enabled single-port data RAM: checks range,
// alignment and funct3, drives the RAM and returns extended load data or a store ack.
module dram_lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input logic            clk,
  input logic            rst,
  dram_lsu_ctrl_if.slave lsu_io
);
  localparam int unsigned TagLsb = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StRd, StRsp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        in_range, misaligned, illegal, req_err;
  logic        idle, accept, wr_en;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode; funct3[1:0] encodes access size for both loads and stores.
  always_comb begin
    in_range = lsu_io.req_addr[31:TagLsb] == BASE_ADDR[31:TagLsb];
    case (lsu_io.req_funct3[1:0])
      2'b01:   misaligned = lsu_io.req_addr[0];
      2'b10:   misaligned = |lsu_io.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (lsu_io.req_we) begin
      illegal = lsu_io.req_funct3[2] || (lsu_io.req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (lsu_io.req_funct3[1:0] == 2'b11) || (lsu_io.req_funct3 == 3'b110);
    end
    req_err = !in_range || misaligned || illegal;
  end

  assign idle   = state_q == StIdle;
  assign accept = rst && idle && lsu_io.req_valid;
  assign wr_en  = accept && lsu_io.req_we && !req_err;

  always_comb begin
    case (lsu_io.req_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << lsu_io.req_addr[1:0];
        wr_data = {4{lsu_io.req_wdata[7:0]}};
      end
      2'b01: begin
        be      = lsu_io.req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{lsu_io.req_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = lsu_io.req_wdata;
      end
    endcase
  end

  assign lsu_io.req_ready      = rst && idle;
  assign lsu_io.mem_addr       = lsu_io.req_addr[ADDR_WIDTH+1:2];
  assign lsu_io.mem_wr_data    = wr_data;
  assign lsu_io.mem_wr_en      = wr_en;
  assign lsu_io.mem_wr_byte_en = wr_en ? be : 4'b0000;

  // Lane select and extension of the RAM word for the latched load.
  always_comb begin
    ld_byte = lsu_io.mem_rd_data[{off_q, 3'b000} +: 8];
    ld_half = lsu_io.mem_rd_data[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = lsu_io.mem_rd_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err || lsu_io.req_we) begin
            state_d = StRsp;
            err_d   = req_err;
            rdata_d = 32'h0;
          end else begin
            state_d = StRd;
            off_d   = lsu_io.req_addr[1:0];
            f3_d    = lsu_io.req_funct3;
          end
        end
      end
      StRd: begin
        state_d = StRsp;
        err_d   = 1'b0;
        rdata_d = ld_data;
      end
      StRsp: begin
        if (lsu_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign lsu_io.rsp_valid = state_q == StRsp;
  assign lsu_io.rsp_err   = err_q;
  assign lsu_io.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dram_lsu_ctrl.sv
// Self-checking bench for dram_lsu_ctrl: directed cases plus random loads/stores checked
// against a byte-addressed memory model.
module tb_dram_lsu_ctrl;
  localparam int unsigned AW       = 14;
  localparam logic [31:0] Base     = 32'h1000_0000;
  localparam int unsigned WinBytes = 4 * (2 ** AW);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dram_lsu_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  dram_lsu_ctrl #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (Base)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .lsu_io(bus.slave)
  );

  // Single-port RAM, one-cycle read latency, no output register.
  logic [31:0] ram [2**AW] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wr_byte_en[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
      end
    end
    bus.mem_rd_data <= ram[bus.mem_addr];
  end

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference memory, byte offset from Base -> byte value.
  byte unsigned ref_mem [int unsigned];

  function automatic logic [7:0] ref_byte(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
    int unsigned size, off, lat, exp_lat, lane;
    logic        legal, err, exp_wen;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd;

    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off   = addr - Base;
    lane  = addr % 4;
    err   = !legal || (off >= WinBytes) || ((addr % size) != 0);
    exp_wen = we && !err;
    exp_be  = 4'b0000;
    exp_rd  = 32'h0;
    if (exp_wen) begin
      for (int i = 0; i < int'(size); i++) begin
        exp_be[lane + i] = 1'b1;
        ref_mem[off + i] = wdata[8*i +: 8];
      end
    end
    if (!we && !err) begin
      for (int i = 0; i < int'(size); i++) exp_rd[8*i +: 8] = ref_byte(off + i);
      if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*size));
    end
    exp_lat = (we || err) ? 1 : 2;

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.rsp_ready  = 1'b0;
    #1;
    check_eq("req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("wr_en", 32'(bus.mem_wr_en), 32'(exp_wen));
    check_eq("byte_en", 32'(bus.mem_wr_byte_en), 32'(exp_be));
    check_eq("mem_addr", 32'(bus.mem_addr), (addr >> 2) % (2 ** AW));
    if (exp_wen) begin
      for (int i = 0; i < int'(size); i++) begin
        check_eq("wr_lane", 32'(bus.mem_wr_data[8*(lane+i) +: 8]), 32'(wdata[8*i +: 8]));
      end
    end

    // Request stays asserted while busy; it must not be accepted or written again.
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check_eq("busy_ready", 32'(bus.req_ready), 32'd0);
      check_eq("busy_wen", 32'(bus.mem_wr_en), 32'd0);
    end while (!bus.rsp_valid && lat < 8);
    bus.req_valid = 1'b0;
    check_eq("latency", lat, exp_lat);
    check_eq("rsp_err", 32'(bus.rsp_err), 32'(err));
    check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_err", 32'(bus.rsp_err), 32'(err));
      check_eq("hold_rdata", bus.rsp_rdata, exp_rd);
      check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("hs_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("hs_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b0;
  endtask

  // Reset while a load waits for RAM data; a store presented during reset must not write.
  task automatic reset_mid(input logic [31:0] addr);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = addr;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'hA5A5_A5A5;
    rst           = 1'b0;
    #1;
    check_eq("rstmid_wen", 32'(bus.mem_wr_en), 32'd0);
    check_eq("rstmid_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check_eq("rstmid_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rstmid_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rstmid_rdata", bus.rsp_rdata, 32'h0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    check_eq("rstmid_idle", 32'(bus.req_ready), 32'd1);
    check_eq("rstmid_novalid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    int unsigned r;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 32'(bus.req_ready), 32'd1);

    run_req(1'b1, 3'd2, Base + 32'h8, 32'hDEAD_BEEF, 0);
    run_req(1'b0, 3'd2, Base + 32'h8, 32'h0, 0);
    run_req(1'b1, 3'd0, Base + 32'h3, 32'h0000_0080, 0);
    run_req(1'b0, 3'd0, Base + 32'h3, 32'h0, 0);
    run_req(1'b0, 3'd4, Base + 32'h3, 32'h0, 0);
    run_req(1'b1, 3'd1, Base + 32'h6, 32'h0000_8001, 0);
    run_req(1'b0, 3'd1, Base + 32'h6, 32'h0, 0);
    run_req(1'b0, 3'd5, Base + 32'h6, 32'h0, 0);
    run_req(1'b0, 3'd2, Base + 32'h2, 32'h0, 0);
    run_req(1'b1, 3'd2, 32'h2000_0000, 32'h1234_5678, 0);
    run_req(1'b0, 3'd3, Base, 32'h0, 0);
    run_req(1'b0, 3'd2, Base + 32'h8, 32'h0, 5);
    reset_mid(Base + 32'h8);
    run_req(1'b0, 3'd2, Base + 32'h8, 32'h0, 0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom();
      else if (r == 1) addr = Base + WinBytes + $urandom_range(0, 15);
      else             addr = Base + $urandom_range(0, 47);
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom(),
              $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
